// File: rtl/nonogram_pkg.sv
// nonogram_pkg
//   Shared sizing and types for the solution return path.
//   MAX_ROWS/MAX_COLS bound the board. A solution bit index is r*MAX_COLS + c.
//   BYTES_PER_ROW is the number of LSB-first bytes emitted for each row.
//   packer_state_t is the state type of the solution_packer FSM.
package nonogram_pkg;

   localparam int MAX_ROWS      = 11;
   localparam int MAX_COLS      = 11;
   localparam int BYTES_PER_ROW = (MAX_COLS + 7) / 8;
   localparam int SOL_W         = MAX_ROWS * MAX_COLS;

   // Widths of the host-supplied dimension inputs.
   localparam int M_W = $clog2(MAX_ROWS);
   localparam int N_W = $clog2(MAX_COLS);

   // Widths of the internal counters and of the clipped dimensions.
   localparam int R_W = $clog2(MAX_ROWS + 1);
   localparam int C_W = $clog2(MAX_COLS + 1);
   localparam int K_W = $clog2(BYTES_PER_ROW + 1);

   typedef enum logic [2:0] {
      IDLE,
      HDR,
      ROW,
      ACK,
      DRAIN,
      FIN
   } packer_state_t;

   // Clamp a requested row count to the board size.
   function automatic logic [R_W-1:0] clip_rows(input logic [M_W-1:0] v);
      return (int'(v) > MAX_ROWS) ? R_W'(MAX_ROWS) : R_W'(v);
   endfunction

   // Clamp a requested column count to the board size.
   function automatic logic [C_W-1:0] clip_cols(input logic [N_W-1:0] v);
      return (int'(v) > MAX_COLS) ? C_W'(MAX_COLS) : C_W'(v);
   endfunction

endpackage

// File: rtl/row_byte_select.sv
// row_byte_select
//   Combinational selector that picks byte k of row r out of the captured
//   solution bitmap. Bit j of the result is cell (r, 8k+j). Columns at or
//   beyond n_eff, or beyond the board width, read as 0.
//   Ports:
//     solution_i  captured bitmap, bit r*MAX_COLS + c = cell (r,c)
//     r_i         row index; rows outside the board give 0x00
//     k_i         byte index within the row; out of range gives 0x00
//     n_eff_i     active column count (already clipped)
//     byte_o      masked byte
module row_byte_select
   import nonogram_pkg::*;
(
   input  logic [SOL_W-1:0] solution_i,
   input  logic [R_W-1:0]   r_i,
   input  logic [K_W-1:0]   k_i,
   input  logic [C_W-1:0]   n_eff_i,
   output logic [7:0]       byte_o
);

   localparam int PAD_W = BYTES_PER_ROW * 8;

   logic [MAX_COLS-1:0] row_sel;
   logic [MAX_COLS-1:0] col_mask;
   logic [PAD_W-1:0]    row_pad;

   // Row mux: constant part-selects per row, picked by comparison.
   always_comb begin
      row_sel = '0;
      for (int rr = 0; rr < MAX_ROWS; rr++) begin
         if (int'(r_i) == rr) begin
            row_sel = solution_i[rr*MAX_COLS +: MAX_COLS];
         end
      end
   end

   // Thermometer mask of the active columns.
   always_comb begin
      col_mask = '0;
      for (int c = 0; c < MAX_COLS; c++) begin
         col_mask[c] = (c < int'(n_eff_i));
      end
   end

   // Zero-pad the row to whole bytes so the final byte's upper bits are 0.
   assign row_pad = PAD_W'(row_sel & col_mask);

   always_comb begin
      byte_o = '0;
      for (int kk = 0; kk < BYTES_PER_ROW; kk++) begin
         if (int'(k_i) == kk) begin
            byte_o = row_pad[kk*8 +: 8];
         end
      end
   end

endmodule

// File: rtl/solution_packer.sv
// solution_packer
//   Captures a solved board once and streams it to the UART transmitter as
//   one header byte {m_eff, n_eff} followed by BYTES_PER_ROW bytes per row.
//   Exactly one byte is in flight: after each byte the FSM waits for the
//   transmitter to drop tx_ready (byte taken) and raise it again (byte sent).
//   Ports:
//     clk, rst_n   clock, asynchronous active-low reset
//     valid_in     1-cycle start pulse; solution/m/n sampled with it
//     solution     solved bitmap, 1 = filled
//     m, n         requested row/column counts (clipped to the board)
//     tx_ready     transmitter idle level
//     byte_valid   1-cycle pulse with byte_out
//     byte_out     registered byte, holds between pulses
//     busy         high from capture until the done cycle
//     done         1-cycle pulse once the last byte has been transmitted
module solution_packer
   import nonogram_pkg::*;
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             valid_in,
   input  logic [SOL_W-1:0] solution,
   input  logic [M_W-1:0]   m,
   input  logic [N_W-1:0]   n,
   input  logic             tx_ready,
   output logic             byte_valid,
   output logic [7:0]       byte_out,
   output logic             busy,
   output logic             done
);

   localparam logic [K_W-1:0] K_LAST = K_W'(BYTES_PER_ROW - 1);

   packer_state_t    state_q, state_d;
   logic [SOL_W-1:0] sol_q, sol_d;
   logic [R_W-1:0]   m_eff_q, m_eff_d;
   logic [C_W-1:0]   n_eff_q, n_eff_d;
   logic [R_W-1:0]   r_q, r_d;
   logic [K_W-1:0]   k_q, k_d;
   // Set once the first row byte has gone out; distinguishes the DRAIN that
   // follows the header from the DRAINs that follow row bytes.
   logic             row_phase_q, row_phase_d;
   logic             byte_valid_q, byte_valid_d;
   logic [7:0]       byte_out_q, byte_out_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;

   logic [7:0]       sel_byte;
   logic [R_W-1:0]   r_inc;

   assign r_inc = r_q + 1'b1;

   row_byte_select u_sel (
      .solution_i (sol_q),
      .r_i        (r_q),
      .k_i        (k_q),
      .n_eff_i    (n_eff_q),
      .byte_o     (sel_byte)
   );

   always_comb begin
      state_d      = state_q;
      sol_d        = sol_q;
      m_eff_d      = m_eff_q;
      n_eff_d      = n_eff_q;
      r_d          = r_q;
      k_d          = k_q;
      row_phase_d  = row_phase_q;
      byte_valid_d = 1'b0;
      byte_out_d   = byte_out_q;
      busy_d       = busy_q;
      done_d       = 1'b0;

      case (state_q)
         IDLE: begin
            if (valid_in) begin
               sol_d       = solution;
               m_eff_d     = clip_rows(m);
               n_eff_d     = clip_cols(n);
               r_d         = '0;
               k_d         = '0;
               row_phase_d = 1'b0;
               busy_d      = 1'b1;
               state_d     = HDR;
            end
         end
         HDR: begin
            if (tx_ready) begin
               byte_valid_d = 1'b1;
               byte_out_d   = {m_eff_q[3:0], n_eff_q[3:0]};
               state_d      = ACK;
            end
         end
         ROW: begin
            if (tx_ready) begin
               byte_valid_d = 1'b1;
               byte_out_d   = sel_byte;
               row_phase_d  = 1'b1;
               state_d      = ACK;
            end
         end
         ACK: begin
            if (!tx_ready) begin
               state_d = DRAIN;
            end
         end
         DRAIN: begin
            if (tx_ready) begin
               if (!row_phase_q) begin
                  // Header just finished; r/k already point at row 0 byte 0.
                  state_d = (m_eff_q == '0) ? FIN : ROW;
               end else if (k_q == K_LAST) begin
                  k_d     = '0;
                  r_d     = r_inc;
                  state_d = (r_inc == m_eff_q) ? FIN : ROW;
               end else begin
                  k_d     = k_q + 1'b1;
                  state_d = ROW;
               end
               // done and busy are registered, so they change on FIN entry.
               if (state_d == FIN) begin
                  done_d = 1'b1;
                  busy_d = 1'b0;
               end
            end
         end
         FIN: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         sol_q        <= '0;
         m_eff_q      <= '0;
         n_eff_q      <= '0;
         r_q          <= '0;
         k_q          <= '0;
         row_phase_q  <= 1'b0;
         byte_valid_q <= 1'b0;
         byte_out_q   <= '0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         sol_q        <= sol_d;
         m_eff_q      <= m_eff_d;
         n_eff_q      <= n_eff_d;
         r_q          <= r_d;
         k_q          <= k_d;
         row_phase_q  <= row_phase_d;
         byte_valid_q <= byte_valid_d;
         byte_out_q   <= byte_out_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
      end
   end

   assign byte_valid = byte_valid_q;
   assign byte_out   = byte_out_q;
   assign busy       = busy_q;
   assign done       = done_q;

endmodule

// File: tb/tb_solution_packer.sv
// Bench for solution_packer: directed frames, expected bytes queued by the
// stimulus, popped and compared by an independent monitor.
module tb_solution_packer;
   import nonogram_pkg::*;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             valid_in;
   logic [SOL_W-1:0] solution;
   logic [M_W-1:0]   m;
   logic [N_W-1:0]   n;
   logic             tx_ready;
   logic             byte_valid;
   logic [7:0]       byte_out;
   logic             busy;
   logic             done;

   int checks = 0;
   int errors = 0;
   int bv_cnt = 0;
   int done_cnt = 0;
   logic [7:0] exp_q[$];

   // Transmitter model: busy for tx_delay cycles after each accepted byte.
   int tx_cnt = 0;
   int tx_delay = 10;
   bit tx_hold = 1'b0;
   assign tx_ready = (tx_cnt == 0) && !tx_hold;

   always #5 clk = ~clk;

   solution_packer dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .valid_in   (valid_in),
      .solution   (solution),
      .m          (m),
      .n          (n),
      .tx_ready   (tx_ready),
      .byte_valid (byte_valid),
      .byte_out   (byte_out),
      .busy       (busy),
      .done       (done)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Transmitter model and one-in-flight check.
   always @(negedge clk) begin
      bit rdy;
      rdy = tx_ready;
      if (!rst_n) begin
         tx_cnt = 0;
      end else begin
         if (tx_cnt > 0) tx_cnt--;
         if (byte_valid) begin
            checks++;
            if (!rdy) begin
               errors++;
               $display("FAIL byte_while_tx_busy: got byte %0h with tx_ready 0 expected tx_ready 1", byte_out);
            end
            tx_cnt = tx_delay;
         end
      end
   end

   // Monitor / scoreboard.
   always @(negedge clk) begin
      logic [7:0] e;
      if (rst_n) begin
         if (byte_valid) begin
            bv_cnt++;
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL unexpected_byte: got %0h expected no byte", byte_out);
            end else begin
               e = exp_q.pop_front();
               if (byte_out !== e) begin
                  errors++;
                  $display("FAIL stream_byte: got %0h expected %0h", byte_out, e);
               end
            end
         end
         if (done) done_cnt++;
      end
   end

   function automatic logic [SOL_W-1:0] mk_sol(input logic [10:0] r0, input logic [10:0] r1,
                                               input logic [10:0] r2, input logic [10:0] rest);
      logic [SOL_W-1:0] s;
      s = '0;
      for (int r = 0; r < MAX_ROWS; r++) s[r*MAX_COLS +: MAX_COLS] = rest;
      s[0 +: 11]  = r0;
      s[11 +: 11] = r1;
      s[22 +: 11] = r2;
      return s;
   endfunction

   task automatic push_t2();
      exp_q.push_back(8'h35);
      exp_q.push_back(8'h15); exp_q.push_back(8'h00);
      exp_q.push_back(8'h0A); exp_q.push_back(8'h00);
      exp_q.push_back(8'h1F); exp_q.push_back(8'h00);
   endtask

   task automatic push_full();
      exp_q.push_back(8'hBB);
      for (int i = 0; i < 11; i++) begin
         exp_q.push_back(8'hFF);
         exp_q.push_back(8'h07);
      end
   endtask

   task automatic run_frame(input logic [SOL_W-1:0] sol, input logic [3:0] mm, input logic [3:0] nn,
                            input int hold_cyc, input int repulse_at, input bit chk_lat);
      int d0, bv0;
      bit got;
      d0 = done_cnt;
      @(negedge clk);
      if (hold_cyc > 0) tx_hold = 1'b1;
      solution = sol; m = mm; n = nn; valid_in = 1'b1;
      @(negedge clk);
      valid_in = 1'b0;
      chk("busy_after_capture", 32'(busy), 32'd1);
      if (chk_lat) begin
         @(negedge clk);
         chk("first_byte_latency", 32'(byte_valid), 32'd1);
      end
      if (hold_cyc > 0) begin
         bv0 = bv_cnt;
         repeat (hold_cyc) @(negedge clk);
         chk("no_byte_while_held", 32'(bv_cnt), 32'(bv0));
         tx_hold = 1'b0;
      end
      got = 1'b0;
      for (int i = 0; i < 4000; i++) begin
         @(negedge clk);
         if (i == repulse_at) begin
            solution = ~sol; m = 4'd7; n = 4'd2; valid_in = 1'b1;
         end else begin
            valid_in = 1'b0;
         end
         if (done_cnt > d0) begin
            got = 1'b1;
            break;
         end
      end
      valid_in = 1'b0;
      if (!got) begin
         checks++; errors++;
         $display("FAIL done_timeout: got no done expected done within 4000 cycles");
      end
      repeat (5) @(negedge clk);
      chk("single_done", 32'(done_cnt), 32'(d0 + 1));
      chk("busy_low_after", 32'(busy), 32'd0);
      chk("queue_empty", 32'(exp_q.size()), 32'd0);
      exp_q.delete();
   endtask

   initial begin
      int bv0, d0;
      rst_n = 1'b0; valid_in = 1'b0; solution = '0; m = '0; n = '0;
      #12;
      chk("rst_byte_valid", 32'(byte_valid), 32'd0);
      chk("rst_byte_out", 32'(byte_out), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);

      // m=3 n=5, rows 0x15/0x0A/0x1F
      push_t2();
      run_frame(mk_sol(11'h015, 11'h00A, 11'h01F, 11'h000), 4'd3, 4'd5, 0, -1, 1'b1);

      // 11x11 all ones
      push_full();
      run_frame({SOL_W{1'b1}}, 4'd11, 4'd11, 0, -1, 1'b0);

      // header only
      exp_q.push_back(8'h04);
      run_frame({SOL_W{1'b1}}, 4'd0, 4'd4, 0, -1, 1'b0);

      // restart attempt mid-frame is ignored
      push_t2();
      run_frame(mk_sol(11'h015, 11'h00A, 11'h01F, 11'h000), 4'd3, 4'd5, 0, 30, 1'b0);

      // transmitter held off for 500 cycles
      push_t2();
      run_frame(mk_sol(11'h015, 11'h00A, 11'h01F, 11'h000), 4'd3, 4'd5, 500, -1, 1'b0);

      // column mask inside the second byte: n=9
      exp_q.push_back(8'h29);
      exp_q.push_back(8'hFF); exp_q.push_back(8'h01);
      exp_q.push_back(8'hFF); exp_q.push_back(8'h01);
      run_frame({SOL_W{1'b1}}, 4'd2, 4'd9, 0, -1, 1'b0);

      // oversize m/n clamp to the board
      push_full();
      run_frame({SOL_W{1'b1}}, 4'd15, 4'd15, 0, -1, 1'b0);

      // asynchronous reset in the middle of a frame
      push_full();
      @(negedge clk);
      solution = {SOL_W{1'b1}}; m = 4'd11; n = 4'd11; valid_in = 1'b1;
      @(negedge clk);
      valid_in = 1'b0;
      repeat (40) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("midrst_byte_valid", 32'(byte_valid), 32'd0);
      chk("midrst_byte_out", 32'(byte_out), 32'd0);
      chk("midrst_busy", 32'(busy), 32'd0);
      chk("midrst_done", 32'(done), 32'd0);
      exp_q.delete();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      bv0 = bv_cnt; d0 = done_cnt;
      repeat (50) @(negedge clk);
      chk("post_rst_no_byte", 32'(bv_cnt), 32'(bv0));
      chk("post_rst_no_done", 32'(done_cnt), 32'(d0));
      chk("post_rst_busy", 32'(busy), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
